fdiv_iter: RTL and testbench

- Iterative single-precision floating-point divider: y = x1 / x2, one quotient bit per cycle.
- Sits in the FPU next to the pipelined add/sub/mul units and serves the multi-cycle divide instruction.
- Valid/ready handshake on both sides, so the core issue stage can stall on it.
- Numeric conventions match the fsub unit:
  - Denormal inputs and outputs are flushed to zero.
  - Rounding is round-to-nearest-even.
  - Exponent-255 inputs (inf/NaN) are don't-care.

---
 rtl/fdiv_iter.sv | 243 ++++++++++++++++++++++++
 tb/tb_fdiv_iter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_iter.sv
// ---------------------------------------------------------------------------
// fdiv_iter -- iterative single-precision floating-point divider, y = x1 / x2.
//
// A restoring divider that produces one quotient bit per clock. It computes
// 26 quotient bits: the 24-bit significand plus guard and round bits. The
// final remainder supplies the sticky bit.
//
// Numeric behaviour matches the fsub unit:
//   - Denormal operands and results are flushed to zero.
//   - Rounding is round-to-nearest-even.
//   - Exponent-255 operands (inf/NaN) are treated as don't-care.
//
// Only one divide is in flight at a time. The request side accepts only in
// IDLE. The response is held in DONE until the consumer takes it.
//
// Ports:
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset; aborts any divide in flight
//   req_valid   x1/x2 valid (sampled only while req_ready is high)
//   req_ready   divider is idle and can accept a request
//   x1          dividend, IEEE-754 single
//   x2          divisor, IEEE-754 single
//   resp_valid  y/ovf valid
//   resp_ready  consumer accepts the result
//   y           quotient, IEEE-754 single
//   ovf         result overflowed, or divide by zero
//   busy        high in any state other than IDLE
// ---------------------------------------------------------------------------
module fdiv_iter #(
    // Quotient bits generated: 24 significand + guard + round.
    // The datapath widths below are sized for exactly 26.
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Operation registers.
    logic              sign;
    logic signed [9:0] expo;
    logic [25:0]       rem;
    logic [23:0]       divisor;
    logic [25:0]       quot;
    logic [4:0]        cnt;

    // Request decode.
    logic              accept;
    logic [7:0]        x1_exp;
    logic [7:0]        x2_exp;
    logic              req_sign;
    logic              div_by_zero;
    logic              zero_dividend;

    // One restoring-division step.
    logic              q_bit;
    logic [25:0]       rem_sub;
    logic [25:0]       rem_next;

    // Normalisation and rounding.
    logic [25:0]       norm_q;
    logic signed [9:0] norm_e;
    logic [23:0]       sig;
    logic              guard;
    logic              sticky_all;
    logic              round_up;
    logic [24:0]       sig_rnd;
    logic [22:0]       frac;
    logic signed [9:0] e_fin;
    logic [31:0]       y_round;
    logic              ovf_round;

    assign accept        = req_valid && req_ready;
    assign x1_exp        = x1[30:23];
    assign x2_exp        = x2[30:23];
    assign req_sign      = x1[31] ^ x2[31];
    assign div_by_zero   = (x2_exp == 8'd0);
    assign zero_dividend = (x1_exp == 8'd0);

    // The remainder always stays below twice the divisor, which is less than
    // 2^25. The left shift therefore never loses a set bit out of the
    // 26-bit register.
    always_comb begin
        q_bit    = (rem >= {2'b00, divisor});
        rem_sub  = q_bit ? (rem - {2'b00, divisor}) : rem;
        rem_next = {rem_sub[24:0], 1'b0};
    end

    // quot[25] is the integer bit of m1/m2.
    // When m1 < m2 the quotient lies in [0.5, 1), so quot[24] is the leading
    // one. Shifting it up costs one exponent step. Any bits left in the
    // remainder become the sticky bit.
    always_comb begin
        norm_q     = quot[25] ? quot : {quot[24:0], 1'b0};
        norm_e     = quot[25] ? expo : (expo - 10'sd1);
        sig        = norm_q[25:2];
        guard      = norm_q[1];
        sticky_all = norm_q[0] | (rem != 26'd0);
        round_up   = guard & (sticky_all | sig[0]);
        sig_rnd    = {1'b0, sig} + {24'd0, round_up};
        // A carry out of rounding leaves 1.000..0 after the right shift,
        // so the fraction field is all zeros either way.
        frac       = sig_rnd[24] ? sig_rnd[23:1] : sig_rnd[22:0];
        e_fin      = sig_rnd[24] ? (norm_e + 10'sd1) : norm_e;
        y_round    = {sign, e_fin[7:0], frac};
        ovf_round  = 1'b0;
        if (e_fin <= 10'sd0) begin
            y_round = {sign, 31'd0};
        end else if (e_fin >= 10'sd255) begin
            y_round   = {sign, 8'hFF, 23'd0};
            ovf_round = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Zero operands are resolved at accept time and skip
    // the iteration entirely.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (div_by_zero || zero_dividend) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            DIV: begin
                if (cnt == 5'd0) begin
                    state_next = ROUND;
                end
            end
            ROUND: begin
                state_next = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake and status outputs come straight from the state.
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            DONE: begin
                resp_valid = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Datapath.
    // The biased exponent difference is kept 10-bit signed, so underflow
    // (<= 0) and overflow (>= 255) stay visible through the normalisation
    // and rounding adjustments.
    // y/ovf are only written on accept of a special case or in ROUND, which
    // keeps them stable while DONE waits on resp_ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign    <= 1'b0;
            expo    <= 10'sd0;
            rem     <= 26'd0;
            divisor <= 24'd0;
            quot    <= 26'd0;
            cnt     <= 5'd0;
            y       <= 32'd0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign    <= req_sign;
                        expo    <= $signed({2'b00, x1_exp}) - $signed({2'b00, x2_exp}) + 10'sd127;
                        rem     <= {2'b01, x1[22:0]};
                        divisor <= {1'b1, x2[22:0]};
                        quot    <= 26'd0;
                        cnt     <= 5'(QBITS - 1);
                        if (div_by_zero) begin
                            y   <= {req_sign, 8'hFF, 23'd0};
                            ovf <= 1'b1;
                        end else if (zero_dividend) begin
                            y   <= {req_sign, 31'd0};
                            ovf <= 1'b0;
                        end
                    end
                end
                DIV: begin
                    rem  <= rem_next;
                    quot <= {quot[24:0], q_bit};
                    cnt  <= cnt - 5'd1;
                end
                ROUND: begin
                    y   <= y_round;
                    ovf <= ovf_round;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// ---------------------------------------------------------------------------
// tb_fdiv_iter -- self-checking bench for fdiv_iter.
//
// The stimulus process issues requests and pushes the expected {ovf, y} into
// a queue. A separate monitor pops the queue and compares on every response
// handshake.
//
// Expected values come from two sources:
//   - Constant results for the directed cases.
//   - A reference model for the random cases. It performs exact integer
//     division of the significands, followed by round-to-nearest-even and
//     the flush/overflow rules.
//
// Latency counts edges from the edge after which the request is first
// presented:
//   - Normal divides: 28.
//   - Zero-operand cases: 1.
// ---------------------------------------------------------------------------
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] x1 = 32'd0;
    logic [31:0] x2 = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] y;
    logic        ovf;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [32:0] exp_q[$];

    fdiv_iter #(.QBITS(26)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .x1         (x1),
        .x2         (x2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .y          (y),
        .ovf        (ovf),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: exact significand quotient with 30 extra bits, then RNE.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int              ea;
        int              eb;
        int              e;
        logic            s;
        longint unsigned num;
        longint unsigned den;
        longint unsigned quo;
        longint unsigned rem;
        longint unsigned sig;
        bit              guard;
        bit              sticky;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        if (eb == 0) return {1'b1, s, 8'hFF, 23'd0};
        if (ea == 0) return {1'b0, s, 31'd0};
        num = 64'({1'b1, a[22:0]}) << 30;
        den = 64'({1'b1, b[22:0]});
        quo = num / den;
        rem = num % den;
        e   = ea - eb + 127;
        if (quo >= (64'd1 << 30)) begin
            sig    = quo >> 7;
            guard  = quo[6];
            sticky = (quo[5:0] != 0) || (rem != 0);
        end else begin
            e      = e - 1;
            sig    = quo >> 6;
            guard  = quo[5];
            sticky = (quo[4:0] != 0) || (rem != 0);
        end
        if (guard && (sticky || sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            e   = e + 1;
        end
        if (e <= 0) return {1'b0, s, 31'd0};
        if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
        return {1'b0, s, 8'(e), sig[22:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every response handshake pops one expected entry.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rstn && resp_valid && resp_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_resp: got ovf=%0b y=%h, required no response", ovf, y);
                end else begin
                    e = exp_q.pop_front();
                    if ({ovf, y} !== e) begin
                        n_fail++;
                        $display("[TB] FAIL result: got ovf=%0b y=%h, required ovf=%0b y=%h", ovf, y, e[32], e[31:0]);
                    end
                end
            end
        end
    end

    // Call at posedge+1.
    // Waits for req_ready, presents one request and queues its expected
    // result. Returns the edge count until resp_valid is seen.
    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b,
                                  input logic [32:0] expv, output int lat);
        int w;
        w = 0;
        while (!req_ready && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!req_ready) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL req_ready_timeout: got 0, required 1");
            lat = -1;
            return;
        end
        x1        = a;
        x2        = b;
        req_valid = 1'b1;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        x1        = $urandom;
        x2        = $urandom;
        lat       = 1;
        while (!resp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ry, input logic ro, input string name);
        int lat;
        int want;
        want = (a[30:23] == 8'd0 || b[30:23] == 8'd0) ? 1 : 28;
        apply_stimulus(a, b, {ro, ry}, lat);
        check({name, "_latency"}, 64'(lat), 64'(want));
    endtask

    function automatic logic [31:0] rand_normal(input bit wide);
        logic [7:0] e;
        e = wide ? 8'($urandom_range(1, 254)) : 8'($urandom_range(64, 190));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    initial begin
        int  lat;
        int  w;
        bit  seen;
        logic [31:0] a;
        logic [31:0] b;

        // Reset values.
        #2 rstn = 1'b0;
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_y", 64'(y), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Directed values.
        run_vec(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "six_by_two");
        run_vec(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 1'b0, "one_third");
        run_vec(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 1'b0, "neg_third");
        run_vec(32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, "one_by_one");
        run_vec(32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b1, "overflow");
        run_vec(32'h00800000, 32'h40000000, 32'h00000000, 1'b0, "underflow");
        run_vec(32'h80800000, 32'h40000000, 32'h80000000, 1'b0, "neg_underflow");
        run_vec(32'h40000000, 32'h00000000, 32'h7F800000, 1'b1, "div_zero");
        run_vec(32'h00000000, 32'h40000000, 32'h00000000, 1'b0, "zero_dividend");
        run_vec(32'h00000000, 32'h00000000, 32'h7F800000, 1'b1, "zero_by_zero");

        // Backpressure: result held and requests ignored while in DONE.
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        apply_stimulus(32'h40C00000, 32'h40000000, {1'b0, 32'h40400000}, lat);
        check("bp_latency", 64'(lat), 64'd28);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 64'(resp_valid), 64'd1);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_y", 64'(y), 64'h40400000);
            check("bp_ovf", 64'(ovf), 64'd0);
            x1        = 32'h3F800000;
            x2        = 32'h40400000;
            req_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 64'(resp_valid), 64'd0);
        check("bp_release_ready", 64'(req_ready), 64'd1);
        check("bp_release_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        check("bp_ignored_req", 64'(busy), 64'd0);

        // Reset during DIV aborts the divide without a response.
        x1        = 32'h40C00000;
        x2        = 32'h40000000;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_busy_before_rst", 64'(busy), 64'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_y", 64'(y), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (resp_valid) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("mid_rst_no_resp", 64'(seen), 64'd0);
        run_vec(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "after_rst");

        // Random normal operands against the reference model.
        for (int i = 0; i < 1200; i++) begin
            a = rand_normal(($urandom_range(0, 3) == 0));
            b = rand_normal(($urandom_range(0, 3) == 0));
            apply_stimulus(a, b, ref_div(a, b), lat);
        end

        // Drain.
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        check("pending_responses", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
